// File: rtl/hls4ml_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hls4ml_mac_pkg
// Description : Shared types, width helpers and saturation limits for the
//               hls4ml pipelined multiply/multiply-accumulate unit.
// Revision    : 1.0 - initial release
// ============================================================================
package hls4ml_mac_pkg;

    typedef struct packed {
        logic valid;
        logic acc;
        logic last;
    } beat_sb_t;

    function automatic int prod_width(input int a_width, input int b_width);
        return a_width + b_width + 1;
    endfunction

    function automatic bit acc_width_ok(input int a_width, input int b_width,
                                        input int acc_width);
        return acc_width >= prod_width(a_width, b_width);
    endfunction

    // Wide enough for any practical ACC_WIDTH; callers size-cast the result.
    function automatic logic signed [127:0] sat_max(input int width);
        return (128'sd1 <<< (width - 1)) - 128'sd1;
    endfunction

    function automatic logic signed [127:0] sat_min(input int width);
        return -(128'sd1 <<< (width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hls4ml_mac_delay.sv
`default_nettype none
// ============================================================================
// Module      : hls4ml_mac_delay
// Description : Advance-gated shift register carrying the product and beat
//               sideband between the multiplier and the accumulator level.
// Revision    : 1.0 - initial release
// ============================================================================
module hls4ml_mac_delay
    import hls4ml_mac_pkg::*;
#(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  adv,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  beat_sb_t              in_sb,
    output logic [DATA_WIDTH-1:0] out_data,
    output beat_sb_t              out_sb
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign out_data = in_data;
            assign out_sb   = in_sb;
        end else begin : g_shift
            logic [DATA_WIDTH-1:0] r_data [DEPTH];
            beat_sb_t              r_sb   [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_data[i] <= '0;
                        r_sb[i]   <= '0;
                    end
                end else if (adv) begin
                    r_data[0] <= in_data;
                    r_sb[0]   <= in_sb;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_data[i] <= r_data[i-1];
                        r_sb[i]   <= r_sb[i-1];
                    end
                end
            end

            assign out_data = r_data[DEPTH-1];
            assign out_sb   = r_sb[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/hls4ml_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : hls4ml_mac_pipe
// Description : Parametrised pipelined multiply / multiply-accumulate unit with
//               valid/ready handshake. Define SATURATE_EN for saturating
//               accumulation with a sticky per-packet overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module hls4ml_mac_pipe
    import hls4ml_mac_pkg::*;
#(
    parameter int A_WIDTH   = 13,
    parameter int B_WIDTH   = 9,
    parameter bit A_SIGNED  = 1'b0,
    parameter bit B_SIGNED  = 1'b1,
    parameter int NUM_STAGE = 3,
    parameter int ACC_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ce,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [A_WIDTH-1:0]          in_a,
    input  logic [B_WIDTH-1:0]          in_b,
    input  logic                        in_acc,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_data,
    output logic                        out_ovf
);

    localparam int PROD_WIDTH  = prod_width(A_WIDTH, B_WIDTH);
    localparam int DELAY_DEPTH = NUM_STAGE - 2;

    generate
        if (!acc_width_ok(A_WIDTH, B_WIDTH, ACC_WIDTH) || NUM_STAGE < 2 || NUM_STAGE > 8)
        begin : g_param_check
            $error("hls4ml_mac_pipe: illegal ACC_WIDTH or NUM_STAGE");
        end
    endgenerate

    logic w_adv;
    logic r_out_valid;

    // One global advance: the whole pipe stalls when a held result is not taken.
    assign w_adv    = ce & (~r_out_valid | out_ready);
    assign in_ready = w_adv;

    // ---------------------------------------------------------------- level 1
    logic [A_WIDTH-1:0] r_a;
    logic [B_WIDTH-1:0] r_b;
    beat_sb_t           r_sb1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sb1 <= '0;
        end else if (w_adv) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_sb1 <= beat_sb_t'{valid: in_valid, acc: in_acc, last: in_last};
        end
    end

    // ------------------------------------------------------------ multiplier
    logic                         w_a_msb;
    logic                         w_b_msb;
    logic signed [PROD_WIDTH-1:0] w_a_px;
    logic signed [PROD_WIDTH-1:0] w_b_px;
    logic signed [PROD_WIDTH-1:0] w_prod;

    assign w_a_msb = A_SIGNED ? r_a[A_WIDTH-1] : 1'b0;
    assign w_b_msb = B_SIGNED ? r_b[B_WIDTH-1] : 1'b0;
    assign w_a_px  = {{(PROD_WIDTH-A_WIDTH){w_a_msb}}, r_a};
    assign w_b_px  = {{(PROD_WIDTH-B_WIDTH){w_b_msb}}, r_b};
    // PROD_WIDTH bits always hold the exact product of the extended operands.
    assign w_prod  = w_a_px * w_b_px;

    // -------------------------------------------------------- levels 2..N-1
    logic [PROD_WIDTH-1:0] w_d_prod;
    beat_sb_t              w_d_sb;

    hls4ml_mac_delay #(
        .DEPTH      (DELAY_DEPTH),
        .DATA_WIDTH (PROD_WIDTH)
    ) u_delay (
        .clk      (clk),
        .reset    (reset),
        .adv      (w_adv),
        .in_data  (w_prod),
        .in_sb    (r_sb1),
        .out_data (w_d_prod),
        .out_sb   (w_d_sb)
    );

    logic signed [ACC_WIDTH-1:0] w_prod_acc;

    generate
        if (ACC_WIDTH > PROD_WIDTH) begin : g_prod_ext
            assign w_prod_acc = {{(ACC_WIDTH-PROD_WIDTH){w_d_prod[PROD_WIDTH-1]}}, w_d_prod};
        end else begin : g_prod_same
            assign w_prod_acc = w_d_prod;
        end
    endgenerate

    // ------------------------------------------------------ accumulate level
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] r_out_data;
    logic                        r_out_ovf;
    logic signed [ACC_WIDTH-1:0] w_next;
    logic                        w_ovf_now;

`ifdef SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] C_SAT_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] C_SAT_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

    logic signed [ACC_WIDTH:0] w_sum_x;
    logic                      w_clamp;
    logic                      r_ovf_sticky;

    assign w_sum_x = {r_acc[ACC_WIDTH-1], r_acc} + {w_prod_acc[ACC_WIDTH-1], w_prod_acc};
    assign w_clamp = w_sum_x[ACC_WIDTH] ^ w_sum_x[ACC_WIDTH-1];

    // A packet that has clamped once keeps its clamped value until it closes.
    always_comb begin
        w_next = w_sum_x[ACC_WIDTH-1:0];
        if (r_ovf_sticky) begin
            w_next = r_acc;
        end else if (w_clamp) begin
            w_next = w_sum_x[ACC_WIDTH] ? C_SAT_MIN : C_SAT_MAX;
        end
    end

    assign w_ovf_now = r_ovf_sticky | w_clamp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_adv && w_d_sb.valid && w_d_sb.acc) begin
            r_ovf_sticky <= w_d_sb.last ? 1'b0 : w_ovf_now;
        end
    end
`else
    assign w_next    = r_acc + w_prod_acc;
    assign w_ovf_now = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= 1'b0;
            if (w_d_sb.valid) begin
                if (!w_d_sb.acc) begin
                    // Plain beat bypasses the accumulator so it can sit inside a packet.
                    r_out_data  <= w_prod_acc;
                    r_out_ovf   <= 1'b0;
                    r_out_valid <= 1'b1;
                end else if (!w_d_sb.last) begin
                    r_acc <= w_next;
                end else begin
                    r_out_data  <= w_next;
                    r_out_ovf   <= w_ovf_now;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire
